// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/load-return bus and data-memory command bus of the MEM-stage load/store unit.
interface mem_access_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            funct3;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     store_data;
  logic                  dm_read;
  logic                  dm_write;
  logic [DM_ADDRESS-1:0] dm_addr;
  logic [DATA_W-1:0]     dm_wd;
  logic [DATA_W-1:0]     dm_rd;
  logic [DATA_W-1:0]     load_data;
  logic                  load_valid;
  logic                  misalign_err;

  modport slave (
    input  req_valid, MemRead, MemWrite, funct3, addr, store_data, dm_rd,
    output req_ready, dm_read, dm_write, dm_addr, dm_wd, load_data, load_valid, misalign_err
  );

  modport master (
    output req_valid, MemRead, MemWrite, funct3, addr, store_data, dm_rd,
    input  req_ready, dm_read, dm_write, dm_addr, dm_wd, load_data, load_valid, misalign_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end: word-granular memory commands, sub-word stores as
// read-modify-write, and lane extraction with sign/zero extension for loads.
module mem_access_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic             clk,
  input logic             reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_t;

  state_t                r_state, w_next;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;
  logic [DM_ADDRESS-1:0] r_waddr;
  logic [DATA_W-1:0]     r_sdata;
  logic                  r_err;

  logic [DM_ADDRESS-1:0] w_waddr;
  logic [1:0]            w_off;
  logic                  w_accept, w_f3_ok, w_align_ok, w_bad, w_cap, w_cap_sub;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_W-1:0]     w_ext, w_merge;

  assign w_waddr       = bus.addr[DM_ADDRESS+1:2];
  assign w_off         = bus.addr[1:0];
  assign bus.req_ready = (r_state == IDLE) && !reset;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign bus.misalign_err = r_err;

  // A no-op (neither read nor write) is never rejected, whatever funct3 holds.
  always_comb begin
    w_f3_ok    = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b101);
    w_align_ok = 1'b1;
    if (bus.funct3[1:0] == 2'b01) w_align_ok = !w_off[0];
    if (bus.funct3[1:0] == 2'b10) w_align_ok = (w_off == 2'b00);
    w_bad = (bus.MemRead && bus.MemWrite) ||
            ((bus.MemRead || bus.MemWrite) &&
             (!w_f3_ok || !w_align_ok || (bus.MemWrite && bus.funct3[2])));
  end

  always_comb begin
    w_byte = bus.dm_rd[{r_off, 3'b000} +: 8];
    w_half = bus.dm_rd[{r_off[1], 4'b0000} +: 16];
    case (r_f3)
      3'b000:  w_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b100:  w_ext = {{(DATA_W-8){1'b0}}, w_byte};
      3'b001:  w_ext = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b101:  w_ext = {{(DATA_W-16){1'b0}}, w_half};
      default: w_ext = bus.dm_rd;
    endcase
    w_merge = bus.dm_rd;
    if (r_f3[0]) w_merge[{r_off[1], 4'b0000} +: 16] = r_sdata[15:0];
    else         w_merge[{r_off, 3'b000} +: 8]      = r_sdata[7:0];
  end

  always_comb begin
    w_next         = r_state;
    w_cap          = 1'b0;
    w_cap_sub      = 1'b0;
    bus.dm_read    = 1'b0;
    bus.dm_write   = 1'b0;
    bus.dm_addr    = r_waddr;
    bus.dm_wd      = '0;
    bus.load_data  = '0;
    bus.load_valid = 1'b0;
    if (reset) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && !w_bad && bus.MemRead) begin
            bus.dm_read = 1'b1;
            bus.dm_addr = w_waddr;
            w_cap       = 1'b1;
            w_next      = LOAD_WAIT;
          end else if (w_accept && !w_bad && bus.MemWrite) begin
            bus.dm_addr = w_waddr;
            w_cap       = 1'b1;
            if (bus.funct3 == 3'b010) begin
              bus.dm_write = 1'b1;
              bus.dm_wd    = bus.store_data;
            end else begin
              bus.dm_read = 1'b1;
              w_cap_sub   = 1'b1;
              w_next      = RMW_WRITE;
            end
          end
        end
        LOAD_WAIT: begin
          bus.load_valid = 1'b1;
          bus.load_data  = w_ext;
          w_next         = IDLE;
        end
        RMW_WRITE: begin
          bus.dm_write = 1'b1;
          bus.dm_wd    = w_merge;
          w_next       = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_f3    <= '0;
      r_off   <= '0;
      r_waddr <= '0;
      r_sdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && w_bad;
      if (w_cap) begin
        r_waddr <= w_waddr;
        r_f3    <= bus.funct3;
        r_off   <= w_off;
      end
      if (w_cap_sub) r_sdata <= bus.store_data;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random loads/stores checked
// against a byte-addressed memory model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();
  mem_access_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_chk = 0;
  int n_fail = 0;

  // Data memory with a registered read port plus a preload path for the bench.
  logic [31:0] mem [0:511];
  logic [31:0] rd_q = '0;
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          rd_cnt = 0;
  assign bus.dm_rd = rd_q;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.dm_write) mem[bus.dm_addr] <= bus.dm_wd;
    if (bus.dm_read) begin
      rd_q   <= mem[bus.dm_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Reference model: byte-addressed image of words 0..15.
  logic [7:0] bmem [0:63];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    bus.req_valid = v; bus.MemRead = rd; bus.MemWrite = wr;
    bus.funct3 = f3; bus.addr = a; bus.store_data = sd;
  endtask

  task automatic idle_bus;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick;
    pl_en = 1'b0;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int ba);
    int size;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    v = 0;
    for (int k = 0; k < size; k++) v = v | (32'(bmem[ba + k]) << (8 * k));
    if (!f3[2] && size == 1) v = 32'($signed(v[7:0]));
    if (!f3[2] && size == 2) v = 32'($signed(v[15:0]));
    return v;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    idle_bus;
    tick; tick;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    #2;
    n_chk++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    n_chk++; if ({bus.dm_read, bus.dm_write} !== 2'b00) begin n_fail++; $display("FAIL reset_dm got=%b exp=00", {bus.dm_read, bus.dm_write}); end
    n_chk++; if ({bus.load_valid, bus.misalign_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {bus.load_valid, bus.misalign_err}); end
    tick;
    reset = 1'b0;
    idle_bus;
    #2;
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] as  [5] = '{32'h41, 32'h43, 32'h42, 32'h40, 32'h40};
    logic [31:0] ex  [5] = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    preload(9'h10, 32'h8899AABB);
    for (int i = 0; i < 5; i++) begin
      tick;
      drive(1'b1, 1'b1, 1'b0, f3s[i], as[i], 32'h0);
      #2;
      n_chk++; if ({bus.dm_read, bus.dm_write, bus.dm_addr} !== {2'b10, 9'h010}) begin n_fail++; $display("FAIL load%0d_cmd got=%b/%h exp=10/010", i, {bus.dm_read, bus.dm_write}, bus.dm_addr); end
      tick;
      idle_bus;
      #2;
      n_chk++; if ({bus.load_valid, bus.load_data} !== {1'b1, ex[i]}) begin n_fail++; $display("FAIL load%0d_data got=%b/%h exp=1/%h", i, bus.load_valid, bus.load_data, ex[i]); end
      n_chk++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL load%0d_busy got=%b exp=0", i, bus.req_ready); end
      tick;
      #2;
      n_chk++; if ({bus.req_ready, bus.load_valid, bus.load_data} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL load%0d_done got=%b%b/%h exp=10/0", i, bus.req_ready, bus.load_valid, bus.load_data); end
    end
  endtask

  task automatic test_sub_store;
    preload(9'h10, 32'h11223344);
    tick;
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h42, 32'hDEADBEEF);
    #2;
    n_chk++; if ({bus.dm_read, bus.dm_write} !== 2'b10) begin n_fail++; $display("FAIL sb_read got=%b exp=10", {bus.dm_read, bus.dm_write}); end
    tick;
    idle_bus;
    #2;
    n_chk++; if ({bus.dm_read, bus.dm_write, bus.dm_addr, bus.dm_wd} !== {2'b01, 9'h010, 32'h11EF3344}) begin n_fail++; $display("FAIL sb_write got=%b/%h/%h exp=01/010/11ef3344", {bus.dm_read, bus.dm_write}, bus.dm_addr, bus.dm_wd); end
    tick;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    tick;
    idle_bus;
    #2;
    n_chk++; if (bus.load_data !== 32'h11EF3344) begin n_fail++; $display("FAIL sb_readback got=%h exp=11ef3344", bus.load_data); end
    tick;
  endtask

  task automatic test_reject;
    logic        rds [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        wrs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [6] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b101};
    logic [31:0] as  [6] = '{32'h43, 32'h42, 32'h40, 32'h40, 32'h40, 32'h41};
    for (int i = 0; i < 6; i++) begin
      tick;
      drive(1'b1, rds[i], wrs[i], f3s[i], as[i], 32'h12345678);
      #2;
      n_chk++; if ({bus.dm_read, bus.dm_write, bus.misalign_err} !== 3'b000) begin n_fail++; $display("FAIL rej%0d_T got=%b exp=000", i, {bus.dm_read, bus.dm_write, bus.misalign_err}); end
      tick;
      idle_bus;
      #2;
      n_chk++; if ({bus.misalign_err, bus.req_ready} !== 2'b11) begin n_fail++; $display("FAIL rej%0d_T1 got=%b exp=11", i, {bus.misalign_err, bus.req_ready}); end
      tick;
      #2;
      n_chk++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL rej%0d_T2 got=%b exp=0", i, bus.misalign_err); end
    end
    tick;
    drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'h0);
    #2;
    n_chk++; if ({bus.dm_read, bus.dm_write} !== 2'b00) begin n_fail++; $display("FAIL noop_dm got=%b exp=00", {bus.dm_read, bus.dm_write}); end
    tick;
    idle_bus;
    #2;
    n_chk++; if ({bus.misalign_err, bus.req_ready} !== 2'b01) begin n_fail++; $display("FAIL noop_T1 got=%b exp=01", {bus.misalign_err, bus.req_ready}); end
  endtask

  task automatic test_reset_midway;
    preload(9'h20, 32'hCAFEF00D);
    tick;
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h80, 32'h00000055);
    #2;
    n_chk++; if (bus.dm_read !== 1'b1) begin n_fail++; $display("FAIL rstrmw_read got=%b exp=1", bus.dm_read); end
    tick;
    idle_bus;
    reset = 1'b1;
    #2;
    n_chk++; if (bus.dm_write !== 1'b0) begin n_fail++; $display("FAIL rstrmw_write got=%b exp=0", bus.dm_write); end
    tick;
    reset = 1'b0;
    #2;
    n_chk++; if (mem[9'h20] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rstrmw_mem got=%h exp=cafef00d", mem[9'h20]); end
    n_chk++; if ({bus.req_ready, bus.load_valid} !== 2'b10) begin n_fail++; $display("FAIL rstrmw_after got=%b exp=10", {bus.req_ready, bus.load_valid}); end
    tick;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
    tick;
    idle_bus;
    reset = 1'b1;
    #2;
    n_chk++; if (bus.load_valid !== 1'b0) begin n_fail++; $display("FAIL rstld_valid got=%b exp=0", bus.load_valid); end
    tick;
    reset = 1'b0;
    #2;
    n_chk++; if ({bus.req_ready, bus.load_valid} !== 2'b10) begin n_fail++; $display("FAIL rstld_after got=%b exp=10", {bus.req_ready, bus.load_valid}); end
  endtask

  task automatic test_back_to_back;
    int c0;
    preload(9'h10, 32'h0BADF00D);
    preload(9'h11, 32'h76543210);
    tick;
    c0 = rd_cnt;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h840, 32'h0);
    #2;
    n_chk++; if ({bus.dm_read, bus.dm_addr} !== {1'b1, 9'h010}) begin n_fail++; $display("FAIL wrap_addr got=%b/%h exp=1/010", bus.dm_read, bus.dm_addr); end
    tick;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h44, 32'h0);
    #2;
    n_chk++; if ({bus.req_ready, bus.dm_read, bus.load_valid, bus.load_data} !== {3'b001, 32'h0BADF00D}) begin n_fail++; $display("FAIL b2b_hold got=%b/%h exp=001/0badf00d", {bus.req_ready, bus.dm_read, bus.load_valid}, bus.load_data); end
    tick;
    #2;
    n_chk++; if ({bus.req_ready, bus.dm_read, bus.dm_addr} !== {2'b11, 9'h011}) begin n_fail++; $display("FAIL b2b_accept got=%b/%h exp=11/011", {bus.req_ready, bus.dm_read}, bus.dm_addr); end
    tick;
    idle_bus;
    #2;
    n_chk++; if (bus.load_data !== 32'h76543210) begin n_fail++; $display("FAIL b2b_data got=%h exp=76543210", bus.load_data); end
    tick;
    #2;
    n_chk++; if (rd_cnt - c0 !== 2) begin n_fail++; $display("FAIL b2b_reads got=%0d exp=2", rd_cnt - c0); end
  endtask

  task automatic test_random;
    logic [2:0] f3tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    logic [31:0] w, a, sd, ex;
    logic [2:0]  f3;
    logic        rd, wr, bad;
    int          ba, size, m;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) bmem[4*i + k] = 8'(w >> (8 * k));
      preload(9'(i), w);
    end
    for (int n = 0; n < 300; n++) begin
      ba   = int'($urandom_range(0, 63));
      a    = ($urandom & 32'hFFFF_F800) | 32'(ba);
      f3   = f3tab[$urandom_range(0, 9)];
      m    = int'($urandom_range(0, 9));
      rd   = (m < 5) || (m == 9);
      wr   = (m >= 5);
      sd   = $urandom;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      bad  = (rd && wr) || (f3 == 3'd3) || (f3 > 3'd5) || (wr && f3 >= 3'd4) || (ba % size != 0);
      tick;
      drive(1'b1, rd, wr, f3, a, sd);
      #2;
      if (bad) begin
        n_chk++; if ({bus.dm_read, bus.dm_write} !== 2'b00) begin n_fail++; $display("FAIL rnd%0d_rej_dm got=%b exp=00", n, {bus.dm_read, bus.dm_write}); end
        tick;
        idle_bus;
        #2;
        n_chk++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_rej_err got=%b exp=1", n, bus.misalign_err); end
      end else if (rd) begin
        ex = ref_load(f3, ba);
        tick;
        idle_bus;
        #2;
        n_chk++; if ({bus.load_valid, bus.load_data} !== {1'b1, ex}) begin n_fail++; $display("FAIL rnd%0d_load f3=%0d ba=%0d got=%b/%h exp=1/%h", n, f3, ba, bus.load_valid, bus.load_data, ex); end
        tick;
      end else begin
        for (int k = 0; k < size; k++) bmem[ba + k] = 8'(sd >> (8 * k));
        tick;
        idle_bus;
        if (size != 4) tick;
      end
    end
    tick;
    for (int i = 0; i < 16; i++) begin
      w = ref_load(3'b010, 4 * i);
      n_chk++; if (mem[i] !== w) begin n_fail++; $display("FAIL rnd_mem%0d got=%h exp=%h", i, mem[i], w); end
    end
  endtask

  initial begin
    idle_bus;
    test_reset;
    test_loads;
    test_sub_store;
    test_reject;
    test_reset_midway;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
